// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file / hazard scoreboard slice.
//   DATA_W   : register and operand width
//   ADDR_W   : register address width
//   NREGS    : number of architectural registers
//   REG_ZERO : address of the hardwired-zero register
package regfile_scoreboard_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard_reg_array.sv
// Register storage: 32 x 32-bit, one write port, two asynchronous read
// ports with write-back bypass; r0 always reads as zero and ignores writes.
//   clk, rst_n     : clock, asynchronous active-low reset (clears all regs)
//   we, wa, wd     : write-back strobe, address, data
//   ra1, ra2       : read addresses
//   rdata1, rdata2 : read data (bypassed from wd when wa matches)
module regfile_scoreboard_reg_array
  import regfile_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != REG_ZERO) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (ra1 != REG_ZERO) begin
      if (we && wa == ra1) rdata1 = wd;
      else                 rdata1 = regs[ra1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (ra2 != REG_ZERO) begin
      if (we && wa == ra2) rdata2 = wd;
      else                 rdata2 = regs[ra2];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file, busy-bit hazard scoreboard and execute-stage operand latch
// feeding the ALU.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   iss_valid / iss_ready      : issue handshake (ready is combinational)
//   RA1, RA2, iss_rs1_used/2   : source addresses and which are really read
//   iss_wr, iss_rd             : destination register of the issuing instr
//   RegWrite, WA, WD           : write-back port
//   DR1, DR2, ex_valid         : latched operands and their valid flag
//   busy                       : scoreboard bits, bit 0 always 0
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic              iss_rs1_used,
  input  logic              iss_rs2_used,
  input  logic              iss_wr,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  output logic              ex_valid,
  output logic [NREGS-1:0]  busy
);

  logic [DATA_W-1:0] rdata1, rdata2;
  logic [NREGS-1:0]  pend, busy_nxt;
  logic              accept;

  regfile_scoreboard_reg_array u_regs (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (RegWrite),
    .wa     (WA),
    .wd     (WD),
    .ra1    (RA1),
    .ra2    (RA2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // A register still pending only if no write-back for it lands this cycle;
  // the bypass lets the waiting instruction issue in the write-back cycle.
  always_comb begin
    pend = '0;
    for (int unsigned i = 1; i < NREGS; i++)
      pend[i] = busy[i] && !(RegWrite && WA == ADDR_W'(i));
  end

  assign iss_ready = !(iss_rs1_used && pend[RA1]) &&
                     !(iss_rs2_used && pend[RA2]) &&
                     !(iss_wr       && pend[iss_rd]);
  assign accept    = iss_valid && iss_ready;

  // Clear applied before set so a new writer of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (RegWrite && WA != REG_ZERO)                busy_nxt[WA]     = 1'b0;
    if (accept && iss_wr && iss_rd != REG_ZERO)    busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      DR1      <= '0;
      DR2      <= '0;
      ex_valid <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      ex_valid <= accept;
      if (accept) begin
        DR1 <= rdata1;
        DR2 <= rdata2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [4:0]  RA1 = '0, RA2 = '0, iss_rd = '0, WA = '0;
  logic        iss_rs1_used = 1'b0, iss_rs2_used = 1'b0, iss_wr = 1'b0;
  logic        RegWrite = 1'b0;
  logic [31:0] WD = '0;
  logic [31:0] DR1, DR2;
  logic        ex_valid;
  logic [31:0] busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .RA1(RA1), .RA2(RA2), .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used),
    .iss_wr(iss_wr), .iss_rd(iss_rd), .RegWrite(RegWrite), .WA(WA), .WD(WD),
    .DR1(DR1), .DR2(DR2), .ex_valid(ex_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] m_dr1 = '0, m_dr2 = '0;
  bit          m_exv = 1'b0;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_dr1 = '0;
    m_dr2 = '0;
    m_exv = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int ra);
    if (ra == 0) return 32'h0;
    if (RegWrite && int'(WA) == ra) return WD;
    return m_regs[ra];
  endfunction

  function automatic bit m_waiting(input int r);
    return r != 0 && m_busy[r] && !(RegWrite && int'(WA) == r);
  endfunction

  function automatic bit m_ready();
    if (iss_rs1_used && m_waiting(int'(RA1))) return 1'b0;
    if (iss_rs2_used && m_waiting(int'(RA2))) return 1'b0;
    if (iss_wr && m_waiting(int'(iss_rd)))    return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void m_step();
    bit acc = iss_valid && m_ready();
    if (acc) begin
      m_dr1 = m_read(int'(RA1));
      m_dr2 = m_read(int'(RA2));
    end
    m_exv = acc;
    if (RegWrite && WA != 0) begin
      m_regs[WA] = WD;
      m_busy[WA] = 1'b0;
    end
    if (acc && iss_wr && iss_rd != 0) m_busy[iss_rd] = 1'b1;
  endfunction

  initial m_reset();
  always @(negedge rst_n) m_reset();
  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready",   {31'b0, iss_ready}, {31'b0, m_ready()});
      check("model_exvalid", {31'b0, ex_valid},  {31'b0, m_exv});
      check("model_busy",    busy, m_busy_vec());
      if (m_exv) begin
        check("model_dr1", DR1, m_dr1);
        check("model_dr2", DR2, m_dr2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int ra1, input int ra2, input bit u1, input bit u2,
                       input bit wr, input int rd, input bit rw, input int wa, input logic [31:0] wd);
    iss_valid = v; RA1 = 5'(ra1); RA2 = 5'(ra2); iss_rs1_used = u1; iss_rs2_used = u2;
    iss_wr = wr; iss_rd = 5'(rd); RegWrite = rw; WA = 5'(wa); WD = wd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  function automatic int pick_addr();
    if ($urandom % 4 != 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_dr1", DR1, 32'h0);
    check("rst_exvalid", {31'b0, ex_valid}, 32'h0);
    check("rst_busy", busy, 32'h0);
    tick();
    rst_n = 1'b1;

    // accept r0/r0
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0);
    tick(); idle();
    @(negedge clk);
    check("r0_exvalid", {31'b0, ex_valid}, 32'h1);
    check("r0_dr1", DR1, 32'h0);
    check("r0_dr2", DR2, 32'h0);
    check("r0_busy", busy, 32'h0);

    // write r5 then read it
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h0000_00AA);
    tick(); drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    tick(); idle();
    @(negedge clk);
    check("wr5_dr1", DR1, 32'h0000_00AA);

    // write to r0 ignored, including the bypass
    tick(); drive(1, 0, 0, 1, 1, 0, 0, 1, 0, 32'hFFFF_FFFF);
    tick(); drive(1, 0, 5, 1, 1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("r0wr_dr1", DR1, 32'h0);
    check("r0wr_dr2", DR2, 32'h0);
    tick(); idle();
    @(negedge clk);
    check("r0rd_dr1", DR1, 32'h0);
    check("r0rd_dr2", DR2, 32'h0000_00AA);

    // RAW stall on r3, released by same-cycle write-back
    tick(); drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0);
    tick(); idle();
    @(negedge clk);
    check("raw_busy_set", busy, 32'h0000_0008);
    tick(); drive(1, 0, 3, 0, 1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("raw_stall_ready", {31'b0, iss_ready}, 32'h0);
    tick();
    @(negedge clk);
    check("raw_stall_exvalid", {31'b0, ex_valid}, 32'h0);
    tick(); drive(1, 0, 3, 0, 1, 0, 0, 1, 3, 32'h1234_5678);
    @(negedge clk);
    check("raw_wb_ready", {31'b0, iss_ready}, 32'h1);
    tick(); idle();
    @(negedge clk);
    check("raw_dr2", DR2, 32'h1234_5678);
    check("raw_busy_clr", busy, 32'h0);
    check("raw_exvalid", {31'b0, ex_valid}, 32'h1);

    // WAW on r7: stalled, then accepted in r7's write-back cycle; set wins
    tick(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
    tick(); drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
    @(negedge clk);
    check("waw_stall_ready", {31'b0, iss_ready}, 32'h0);
    tick(); drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 32'h0000_0077);
    @(negedge clk);
    check("waw_wb_ready", {31'b0, iss_ready}, 32'h1);
    tick(); idle();
    @(negedge clk);
    check("waw_busy", busy, 32'h0000_0080);

    // unused busy source never stalls
    tick(); drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 32'h0);
    tick(); drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("unused_ready", {31'b0, iss_ready}, 32'h1);
    tick(); idle();
    @(negedge clk);
    check("unused_exvalid", {31'b0, ex_valid}, 32'h1);

    // asynchronous reset between edges
    tick(); drive(1, 5, 7, 1, 0, 1, 9, 0, 0, 32'h0);
    tick(); idle();
    check("pre_rst_busy", busy, 32'h0000_0290);
    check("pre_rst_exvalid", {31'b0, ex_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 32'h0);
    check("arst_exvalid", {31'b0, ex_valid}, 32'h0);
    check("arst_dr1", DR1, 32'h0);
    check("arst_dr2", DR2, 32'h0);
    tick();
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom % 4 != 0, pick_addr(), pick_addr(), 1'($urandom), 1'($urandom),
            1'($urandom), pick_addr(), $urandom % 3 != 0, pick_addr(), $urandom);
      tick();
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
